// File: rtl/fnd_controller.sv
// 4-digit common-anode FND driver: sequential double-dabble BCD plus digit scan.
// Optional FND_LZ_BLANK_EN blanks leading-zero digits.
module fnd_controller #(
  parameter int          SCAN_DIV = 100_000,
  parameter logic [13:0] MAX_VAL  = 14'd9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] count,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_data,
  output logic        conv_busy
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [13:0]   samp_q, samp_d;
  logic [29:0]   sr_q, sr_d;
  logic [3:0]    it_q, it_d;
  logic [15:0]   disp_q, disp_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    com_q, com_d;
  logic [7:0]    data_q, data_d;

  logic [13:0]   sat;
  logic [15:0]   adj;
  logic          scan_tick;
  logic [3:0]    dig;
  logic [3:0]    lz;

  function automatic logic [7:0] seg(input logic [3:0] d);
    logic [7:0] s;
    unique case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  assign sat = (count > MAX_VAL) ? MAX_VAL : count;

  // add-3 correction on the BCD half before each shift
  always_comb begin
    adj = sr_q[29:14];
    for (int i = 0; i < 4; i++) begin
      if (sr_q[14+4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = sr_q[14+4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    sr_d    = sr_q;
    it_d    = it_q;
    disp_d  = disp_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (sat != samp_q) begin
          samp_d  = sat;
          sr_d    = {16'd0, sat};
          it_d    = 4'd0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d = {adj[14:0], sr_q[13:0], 1'b0};
        it_d = it_q + 4'd1;
        if (it_q == 4'd13) begin
          state_d = DONE;
        end
      end
      DONE: begin
        disp_d  = sr_q[29:14];
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign scan_tick = (div_q == DW'(SCAN_DIV - 1));

  always_comb begin
    div_d = scan_tick ? '0 : div_q + 1'b1;
    sel_d = scan_tick ? sel_q + 2'd1 : sel_q;
  end

`ifdef FND_LZ_BLANK_EN
  always_comb begin
    lz[3] = (disp_q[15:12] == 4'd0);
    lz[2] = lz[3] && (disp_q[11:8] == 4'd0);
    lz[1] = lz[2] && (disp_q[7:4] == 4'd0);
    lz[0] = 1'b0;
  end
`else
  assign lz = 4'b0000;
`endif

  always_comb begin
    unique case (sel_q)
      2'd0:    dig = disp_q[3:0];
      2'd1:    dig = disp_q[7:4];
      2'd2:    dig = disp_q[11:8];
      default: dig = disp_q[15:12];
    endcase
    com_d  = ~(4'b0001 << sel_q);
    data_d = lz[sel_q] ? 8'hFF : seg(dig);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      samp_q  <= '0;
      sr_q    <= '0;
      it_q    <= '0;
      disp_q  <= '0;
      busy_q  <= 1'b0;
      div_q   <= '0;
      sel_q   <= '0;
      com_q   <= 4'b1111;
      data_q  <= 8'hFF;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      sr_q    <= sr_d;
      it_q    <= it_d;
      disp_q  <= disp_d;
      busy_q  <= busy_d;
      div_q   <= div_d;
      sel_q   <= sel_d;
      com_q   <= com_d;
      data_q  <= data_d;
    end
  end

  assign fnd_com   = com_q;
  assign fnd_data  = data_q;
  assign conv_busy = busy_q;

endmodule

// File: tb/tb_fnd_controller.sv
// Self-checking bench for fnd_controller (SCAN_DIV = 4): tables, corner
// sequences and random counts against a decimal-arithmetic display model.
module tb_fnd_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] count;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_data;
  logic        conv_busy;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] got_seg [4];
  logic [7:0] seg_lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int pw [4] = '{1, 10, 100, 1000};

  typedef struct {
    int cnt;
    int val;
  } vec_t;

  vec_t tbl [10];

  always #5 clk = ~clk;

  fnd_controller #(
    .SCAN_DIV(4),
    .MAX_VAL (14'd9999)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .count    (count),
    .fnd_com  (fnd_com),
    .fnd_data (fnd_data),
    .conv_busy(conv_busy)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x > 9999) ? 9999 : x;
  endfunction

  function automatic logic [7:0] exp_seg(input int v, input int k);
    int d;
    d = (v / pw[k]) % 10;
`ifdef FND_LZ_BLANK_EN
    if (k > 0 && v < pw[k]) return 8'hFF;
`endif
    return seg_lut[d];
  endfunction

  function automatic int com_idx(input logic [3:0] c);
    logic [3:0] pat;
    int k;
    k = -1;
    for (int j = 0; j < 4; j++) begin
      pat = ~(4'b0001 << j);
      if (c === pat) k = j;
    end
    return k;
  endfunction

  task automatic wait_idle();
    int stable;
    stable = 0;
    step();
    step();
    for (int i = 0; i < 400 && stable < 3; i++) begin
      step();
      if (conv_busy === 1'b0) stable++;
      else stable = 0;
    end
    chk("idle_wait", (stable >= 3), 1);
  endtask

  task automatic check_display(input string name, input int v);
    logic [3:0] seen;
    int k;
    seen = 4'h0;
    for (int i = 0; i < 16; i++) begin
      step();
      k = com_idx(fnd_com);
      chk({name, "_com"}, (k >= 0), 1);
      if (k >= 0) begin
        chk(name, fnd_data, exp_seg(v, k));
        got_seg[k] = fnd_data;
        seen[k] = 1'b1;
      end
    end
    chk({name, "_cover"}, seen, 4'hF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int k;
    int v;
    logic [3:0] pat;

    tbl[0] = '{0, 0};
    tbl[1] = '{42, 42};
    tbl[2] = '{16383, 9999};
    tbl[3] = '{10000, 9999};
    tbl[4] = '{7, 7};
    tbl[5] = '{9998, 9998};
    tbl[6] = '{305, 305};
    tbl[7] = '{1000, 1000};
    tbl[8] = '{90, 90};
    tbl[9] = '{9999, 9999};

    reset = 1'b1;
    count = 14'd0;
    step();
    step();
    chk("rst_com", fnd_com, 4'b1111);
    chk("rst_data", fnd_data, 8'hFF);
    chk("rst_busy", conv_busy, 1'b0);

    reset = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      step();
      pat = ~(4'b0001 << (((n - 1) / 4) % 4));
      chk("scan_com", fnd_com, pat);
      chk("scan_data", fnd_data, 8'hC0);
      chk("scan_busy", conv_busy, 1'b0);
    end

    count = 14'd1234;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (conv_busy === 1'b1) busy_cnt++;
    end
    chk("busy_len", busy_cnt, 15);
    check_display("d1234", 1234);
    chk("d1234_u", got_seg[0], 8'h99);
    chk("d1234_t", got_seg[1], 8'hB0);
    chk("d1234_h", got_seg[2], 8'hA4);
    chk("d1234_k", got_seg[3], 8'hF9);

    for (int i = 0; i < 10; i++) begin
      count = 14'(tbl[i].cnt);
      wait_idle();
      check_display("table", tbl[i].val);
    end

    count = 14'd40;
    wait_idle();
    check_display("d40", 40);
`ifdef FND_LZ_BLANK_EN
    chk("d40_k", got_seg[3], 8'hFF);
    chk("d40_h", got_seg[2], 8'hFF);
`else
    chk("d40_k", got_seg[3], 8'hC0);
    chk("d40_h", got_seg[2], 8'hC0);
`endif
    chk("d40_t", got_seg[1], 8'h99);
    chk("d40_u", got_seg[0], 8'hC0);

    count = 14'd1234;
    for (int i = 0; i < 5; i++) step();
    count = 14'd5678;
    busy_cnt = 0;
    while (conv_busy === 1'b1 && busy_cnt < 60) begin
      step();
      busy_cnt++;
    end
    chk("first_done", conv_busy, 1'b0);
    step();
    chk("reconv_busy", conv_busy, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      k = com_idx(fnd_com);
      chk("hold_com", (k >= 0), 1);
      if (k >= 0) chk("hold_1234", fnd_data, exp_seg(1234, k));
    end
    wait_idle();
    check_display("d5678", 5678);
    chk("d5678_k", got_seg[3], 8'h92);
    chk("d5678_h", got_seg[2], 8'h82);
    chk("d5678_t", got_seg[1], 8'hF8);
    chk("d5678_u", got_seg[0], 8'h80);

    count = 14'd3000;
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    chk("abort_com", fnd_com, 4'b1111);
    chk("abort_data", fnd_data, 8'hFF);
    chk("abort_busy", conv_busy, 1'b0);
    step();
    count = 14'd7;
    step();
    reset = 1'b0;
    wait_idle();
    check_display("d7", 7);
    chk("d7_u", got_seg[0], 8'hF8);
`ifdef FND_LZ_BLANK_EN
    chk("d7_k", got_seg[3], 8'hFF);
`else
    chk("d7_k", got_seg[3], 8'hC0);
`endif

    for (int i = 0; i < 25; i++) begin
      v = (i % 5 == 0) ? $urandom_range(9990, 16383) : $urandom_range(0, 16383);
      count = 14'(v);
      wait_idle();
      check_display("rand", sat(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
